// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch sequencer in front of a synchronous-read IMEM (1-cycle read latency).
// Latency: a read issued in cycle t is presented to decode in cycle t+2; 1 instr/cycle sustained.
// Backpressure: out reg + 1-entry skid absorb inst_ready=0; issue throttles so nothing is ever dropped.
//
// Ports:
//   clk, reset       clock (posedge) and asynchronous active-high reset
//   fetch_en         allow new reads; when low, in-flight/buffered data still drains
//   imem_addr        word address to IMEM (= fetch PC register)
//   imem_rdata       IMEM data for the address sampled at the previous posedge
//   inst_valid/ready valid/ready handshake to decode; inst_data/inst_pc carry the instruction
//   redirect_valid   1-cycle restart request at redirect_pc; squashes everything buffered/in flight
module imem_fetch_ctrl #(
    parameter int                 ADDR_W   = 12,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic              inflight_q,    inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              out_valid_q,   out_valid_d;
    logic [DATA_W-1:0] out_data_q,    out_data_d;
    logic [ADDR_W-1:0] out_pc_q,      out_pc_d;
    logic              skid_valid_q,  skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,   skid_data_d;
    logic [ADDR_W-1:0] skid_pc_q,     skid_pc_d;

    logic       pop;
    logic       issue;
    logic       out_free;
    logic [1:0] occ;
    logic [1:0] occ_after_pop;

    assign imem_addr  = fetch_pc_q;
    // A redirect hides the current output so decode never consumes a squashed instruction.
    assign inst_valid = out_valid_q & ~redirect_valid;
    assign inst_data  = out_data_q;
    assign inst_pc    = out_pc_q;

    assign pop           = inst_valid & inst_ready;
    assign occ           = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
    assign occ_after_pop = occ - {1'b0, pop};
    // Only issue when the returning word is guaranteed a slot (out or skid) one cycle later.
    assign issue         = fetch_en & ~redirect_valid & (occ_after_pop < 2'd2);
    assign out_free      = ~out_valid_q | pop;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_pc_d      = out_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_data_d   = skid_data_q;
        skid_pc_d     = skid_pc_q;

        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc;
            inflight_d   = 1'b0;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            // Issue side: the memory re-reads the held address when idle; that data is ignored.
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 1'b1;
            end

            // Capture side: skid is older than the returning word, so it moves to out first.
            if (out_free) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = skid_data_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = inflight_q;
                    if (inflight_q) begin
                        skid_data_d = imem_rdata;
                        skid_pc_d   = inflight_pc_q;
                    end
                end else if (inflight_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = imem_rdata;
                    out_pc_d    = inflight_pc_q;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (inflight_q) begin
                // Out is held; the issue throttle guarantees the skid is empty here.
                skid_valid_d = 1'b1;
                skid_data_d  = imem_rdata;
                skid_pc_d    = inflight_pc_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_pc_q      <= '0;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            skid_pc_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_pc_q      <= out_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed bench for imem_fetch_ctrl with a queue-based reference model.
// The model tracks buffered PCs as a FIFO plus one outstanding read; outputs are compared every cycle.
// Literal expectations in the stimulus pin the model and the DUT to hand-computed PC sequences.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [11:0] inst_pc;
    logic        redirect_valid;
    logic [11:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return 32'hA000_0000 + {20'h0, a};
    endfunction

    // Synchronous-read IMEM: data for the address sampled at this edge appears next cycle.
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [11:0] q_pc[$];          // buffered instructions, oldest first
    bit          m_inf = 1'b0;     // one read outstanding
    logic [11:0] m_ipc = 12'h0;
    logic [11:0] m_fpc = 12'h0;

    always @(posedge clk or posedge reset) begin : model
        bit m_pop;
        bit m_iss;
        int n;
        if (reset) begin
            q_pc.delete();
            m_inf = 1'b0;
            m_fpc = 12'h0;
        end else begin
            m_pop = (q_pc.size() > 0) && !redirect_valid && inst_ready;
            n     = q_pc.size() + int'(m_inf) - int'(m_pop);
            m_iss = fetch_en && !redirect_valid && (n < 2);
            if (redirect_valid) begin
                q_pc.delete();
                m_inf = 1'b0;
                m_fpc = redirect_pc;
            end else begin
                if (m_pop) void'(q_pc.pop_front());
                if (m_inf) q_pc.push_back(m_ipc);
                m_inf = m_iss;
                if (m_iss) begin
                    m_ipc = m_fpc;
                    m_fpc = m_fpc + 12'h1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic [11:0] xfer[$];          // PCs of completed transfers, as seen at the DUT

    always @(negedge clk) begin : compare
        bit exp_v;
        #2;
        exp_v = (q_pc.size() > 0) && !redirect_valid;
        chk("imem_addr", {20'h0, imem_addr}, {20'h0, m_fpc});
        chk("inst_valid", {31'h0, inst_valid}, {31'h0, exp_v});
        if (exp_v && inst_valid) begin
            chk("inst_pc", {20'h0, inst_pc}, {20'h0, q_pc[0]});
            chk("inst_data", inst_data, mem_word(q_pc[0]));
        end
        if (inst_valid && inst_ready) xfer.push_back(inst_pc);
    end

    function automatic void chk_xfer(input string nm, input int idx, input logic [11:0] exp);
        if (idx >= xfer.size()) chk({nm, "_missing"}, xfer.size(), idx + 1);
        else                    chk(nm, {20'h0, xfer[idx]}, {20'h0, exp});
    endfunction

    task automatic lit_out(input string nm, input bit v, input logic [11:0] pc);
        chk({nm, "_valid"}, {31'h0, inst_valid}, {31'h0, v});
        if (v) begin
            chk({nm, "_pc"}, {20'h0, inst_pc}, {20'h0, pc});
            chk({nm, "_data"}, inst_data, mem_word(pc));
        end
    endtask

    logic [11:0] wrap_exp[4];
    logic [11:0] last_pc;

    initial begin
        reset = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 12'h0;
        #1;
        chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_imem_addr", {20'h0, imem_addr}, 32'h0);
        chk("rst_inst_pc", {20'h0, inst_pc}, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        repeat (3) @(negedge clk);

        // 1: release, stream from pc 0 in cycle 2
        reset = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
        #3 lit_out("t1_c0", 1'b0, 12'h0);
        @(negedge clk); #3 lit_out("t1_c1", 1'b0, 12'h0);
        @(negedge clk); #3 lit_out("t1_c2", 1'b1, 12'h000);
        @(negedge clk); #3 lit_out("t1_c3", 1'b1, 12'h001);
        @(negedge clk); #3 lit_out("t1_c4", 1'b1, 12'h002);

        // 2: stall 5 cycles while pc 3 is presented
        @(negedge clk);
        inst_ready = 1'b0;
        xfer.delete();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            lit_out("t2_hold", 1'b1, 12'h003);
            chk("t2_addr_stall", {20'h0, imem_addr}, 32'h5);
        end
        @(negedge clk);
        inst_ready = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_xfer("t2_order", i, 12'(3 + i));
        chk("t2_no_dup", xfer.size(), 4);

        // 3: redirect with out and skid both full
        inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 12'h100;
        xfer.delete();
        #3 chk("t3_t0_valid", {31'h0, inst_valid}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0; inst_ready = 1'b1;
        #3 chk("t3_t1_valid", {31'h0, inst_valid}, 32'h0);
        @(negedge clk); #3 chk("t3_t2_valid", {31'h0, inst_valid}, 32'h0);
        @(negedge clk); #3 lit_out("t3_t3", 1'b1, 12'h100);
        @(negedge clk);
        chk_xfer("t3_first", 0, 12'h100);

        // 4: redirect to FFE, wrap through 000
        redirect_valid = 1'b1; redirect_pc = 12'hFFE;
        xfer.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (6) @(negedge clk);
        wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;
        for (int i = 0; i < 4; i++) chk_xfer("t4_wrap", i, wrap_exp[i]);

        // 5: fetch_en drop with ready=1
        fetch_en = 1'b0;
        xfer.delete();
        repeat (6) @(negedge clk);
        #3 chk("t5_drained_valid", {31'h0, inst_valid}, 32'h0);
        chk("t5_at_most_2", {31'h0, xfer.size() <= 2}, 32'h1);
        chk("t5_some_drain", {31'h0, xfer.size() >= 1}, 32'h1);
        last_pc = (xfer.size() > 0) ? xfer[$] : 12'h0;
        @(negedge clk);
        fetch_en = 1'b1;
        xfer.delete();
        repeat (4) @(negedge clk);
        chk_xfer("t5_resume", 0, last_pc + 12'h1);

        // 6: reset pulsed between edges mid-stream
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_valid_now", {31'h0, inst_valid}, 32'h0);
        chk("t6_addr_now", {20'h0, imem_addr}, 32'h0);
        reset = 1'b0;
        @(negedge clk); #3 lit_out("t6_c1", 1'b0, 12'h0);
        @(negedge clk); #3 lit_out("t6_c2", 1'b1, 12'h000);
        @(negedge clk); #3 lit_out("t6_c3", 1'b1, 12'h001);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
